dds_sweep_ctrl: RTL and testbench

Frequency-sweep sequencer for the DDS core. On a start pulse it latches a sweep configuration and drives the DDS `f_ctrl` and `p_ctrl` inputs through a linear ramp from a start word to a stop word. Each point is held for a programmable number of cycles. It sits between the register/config interface and the DDS instance, and is the only writer of the DDS tuning words.

---
 rtl/dds_pkg.sv | 35 +++
 rtl/dds_dwell_cnt.sv | 38 +++
 rtl/dds_sweep_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared types and default widths for the DDS sweep sequencer.
// Build option: DDS_SWEEP_TRI_EN adds the up/down (triangle) sweep mode.
package dds_pkg;

  localparam int F_WORD_N = 32;
  localparam int P_WORD_M = 12;
  localparam int DWELL_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DONE = 2'd3
  } sweep_state_t;

  typedef struct packed {
    logic [F_WORD_N-1:0] f_start;
    logic [F_WORD_N-1:0] f_stop;
    logic [F_WORD_N-1:0] f_step;
    logic [DWELL_W-1:0]  dwell;
    logic [P_WORD_M-1:0] p_offset;
    logic                cont;
`ifdef DDS_SWEEP_TRI_EN
    logic                tri_mode;
`endif
  } sweep_cfg_t;

  // A zero step or an empty/inverted range collapses the sweep to f_start alone.
  function automatic logic is_single_point(input logic [F_WORD_N-1:0] fs,
                                           input logic [F_WORD_N-1:0] fe,
                                           input logic [F_WORD_N-1:0] st);
    return (st == '0) || (fs >= fe);
  endfunction

endpackage

// File: rtl/dds_dwell_cnt.sv
// Loadable down-counter that times how long each sweep point is held.
// Build option: none (DDS_SWEEP_TRI_EN does not affect this block).
module dds_dwell_cnt
  import dds_pkg::*;
#(
  parameter int W = DWELL_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Saturates at zero so the FSM can sample zero on any later cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: ramps the DDS tuning word from f_start to f_stop.
// Build option: DDS_SWEEP_TRI_EN adds tri_mode and the descending (DOWN) leg.
module dds_sweep_ctrl
  import dds_pkg::sweep_state_t, dds_pkg::sweep_cfg_t, dds_pkg::is_single_point,
         dds_pkg::ST_IDLE, dds_pkg::ST_UP, dds_pkg::ST_DOWN, dds_pkg::ST_DONE;
#(
  parameter int F_WORD_N = dds_pkg::F_WORD_N,
  parameter int P_WORD_M = dds_pkg::P_WORD_M,
  parameter int DWELL_W  = dds_pkg::DWELL_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [F_WORD_N-1:0] f_start,
  input  logic [F_WORD_N-1:0] f_stop,
  input  logic [F_WORD_N-1:0] f_step,
  input  logic [DWELL_W-1:0]  dwell,
  input  logic [P_WORD_M-1:0] p_offset,
  input  logic                cont,
`ifdef DDS_SWEEP_TRI_EN
  input  logic                tri_mode,
`endif
  output logic [F_WORD_N-1:0] f_ctrl,
  output logic [P_WORD_M-1:0] p_ctrl,
  output logic                busy,
  output logic                step_stb,
  output logic                done
);

  // Handshake: start is a one-cycle request honoured only in IDLE; abort wins
  // over start and over every busy state. No valid/ready backpressure exists.

  sweep_state_t        state_q, state_d;
  sweep_cfg_t          cfg_q, cfg_d;
  logic [F_WORD_N-1:0] f_ctrl_q, f_ctrl_d;
  logic [P_WORD_M-1:0] p_ctrl_q, p_ctrl_d;
  logic                busy_q, busy_d;
  logic                step_stb_q, step_stb_d;
  logic                done_q, done_d;
  logic                last_q, last_d;

  logic                cnt_load;
  logic [DWELL_W-1:0]  cnt_val;
  logic                cnt_zero;

  logic [F_WORD_N:0]   up_sum;
  logic                up_clamp;
  logic                cfg_single;

  // The extra top bit catches a carry so a wrap can never look like a small word.
  assign up_sum     = {1'b0, f_ctrl_q} + {1'b0, cfg_q.f_step};
  assign up_clamp   = up_sum[F_WORD_N] || (up_sum[F_WORD_N-1:0] >= cfg_q.f_stop);
  assign cfg_single = is_single_point(cfg_q.f_start, cfg_q.f_stop, cfg_q.f_step);

`ifdef DDS_SWEEP_TRI_EN
  logic [F_WORD_N:0]   dn_diff;
  logic                dn_clamp;

  assign dn_diff  = {1'b0, f_ctrl_q} - {1'b0, cfg_q.f_step};
  assign dn_clamp = dn_diff[F_WORD_N] || (dn_diff[F_WORD_N-1:0] <= cfg_q.f_start);
`endif

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    f_ctrl_d   = f_ctrl_q;
    p_ctrl_d   = p_ctrl_q;
    busy_d     = busy_q;
    step_stb_d = 1'b0;
    done_d     = 1'b0;
    last_d     = last_q;
    cnt_load   = 1'b0;
    cnt_val    = cfg_q.dwell;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          cfg_d.f_start  = f_start;
          cfg_d.f_stop   = f_stop;
          cfg_d.f_step   = f_step;
          cfg_d.dwell    = dwell;
          cfg_d.p_offset = p_offset;
          cfg_d.cont     = cont;
`ifdef DDS_SWEEP_TRI_EN
          cfg_d.tri_mode = tri_mode;
`endif
          f_ctrl_d   = f_start;
          p_ctrl_d   = p_offset;
          busy_d     = 1'b1;
          step_stb_d = 1'b1;
          cnt_load   = 1'b1;
          cnt_val    = dwell;
          last_d     = is_single_point(f_start, f_stop, f_step);
          state_d    = ST_UP;
        end
      end

      ST_UP: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          if (!last_q) begin
            f_ctrl_d   = up_clamp ? cfg_q.f_stop : up_sum[F_WORD_N-1:0];
            last_d     = up_clamp;
            step_stb_d = 1'b1;
            cnt_load   = 1'b1;
`ifdef DDS_SWEEP_TRI_EN
          end else if (cfg_q.tri_mode && !cfg_single) begin
            f_ctrl_d   = dn_clamp ? cfg_q.f_start : dn_diff[F_WORD_N-1:0];
            last_d     = dn_clamp;
            step_stb_d = 1'b1;
            cnt_load   = 1'b1;
            state_d    = ST_DOWN;
`endif
          end else if (cfg_q.cont) begin
            f_ctrl_d   = cfg_q.f_start;
            p_ctrl_d   = cfg_q.p_offset;
            last_d     = cfg_single;
            step_stb_d = 1'b1;
            cnt_load   = 1'b1;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

`ifdef DDS_SWEEP_TRI_EN
      ST_DOWN: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          if (!last_q) begin
            f_ctrl_d   = dn_clamp ? cfg_q.f_start : dn_diff[F_WORD_N-1:0];
            last_d     = dn_clamp;
            step_stb_d = 1'b1;
            cnt_load   = 1'b1;
          end else if (cfg_q.cont) begin
            // Re-enter the ascent from the f_start point just emitted.
            f_ctrl_d   = up_clamp ? cfg_q.f_stop : up_sum[F_WORD_N-1:0];
            last_d     = up_clamp;
            step_stb_d = 1'b1;
            cnt_load   = 1'b1;
            state_d    = ST_UP;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
`endif

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cfg_q      <= '0;
      f_ctrl_q   <= '0;
      p_ctrl_q   <= '0;
      busy_q     <= 1'b0;
      step_stb_q <= 1'b0;
      done_q     <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      f_ctrl_q   <= f_ctrl_d;
      p_ctrl_q   <= p_ctrl_d;
      busy_q     <= busy_d;
      step_stb_q <= step_stb_d;
      done_q     <= done_d;
      last_q     <= last_d;
    end
  end

  dds_dwell_cnt #(
    .W (DWELL_W)
  ) u_dwell_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .val   (cnt_val),
    .zero  (cnt_zero)
  );

  assign f_ctrl   = f_ctrl_q;
  assign p_ctrl   = p_ctrl_q;
  assign busy     = busy_q;
  assign step_stb = step_stb_q;
  assign done     = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl; expected point sequences are hand-computed.
// Build option: DDS_SWEEP_TRI_EN enables the triangle-sweep scenario.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] f_start = '0;
  logic [31:0] f_stop = '0;
  logic [31:0] f_step = '0;
  logic [15:0] dwell = '0;
  logic [11:0] p_offset = '0;
  logic        cont = 1'b0;
`ifdef DDS_SWEEP_TRI_EN
  logic        tri_mode = 1'b0;
`endif
  logic [31:0] f_ctrl;
  logic [11:0] p_ctrl;
  logic        busy;
  logic        step_stb;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  int n_stb, n_done, busy_cyc, done_c;

  dds_sweep_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .f_start  (f_start),
    .f_stop   (f_stop),
    .f_step   (f_step),
    .dwell    (dwell),
    .p_offset (p_offset),
    .cont     (cont),
`ifdef DDS_SWEEP_TRI_EN
    .tri_mode (tri_mode),
`endif
    .f_ctrl   (f_ctrl),
    .p_ctrl   (p_ctrl),
    .busy     (busy),
    .step_stb (step_stb),
    .done     (done)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [31:0] fs, input logic [31:0] fe,
                             input logic [31:0] st, input logic [15:0] dw,
                             input logic [11:0] po, input logic cn);
    f_start  = fs;
    f_stop   = fe;
    f_step   = st;
    dwell    = dw;
    p_offset = po;
    cont     = cn;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    // Scramble the live inputs: the sweep must run from its captured copy.
    f_start  = ~fs;
    f_stop   = ~fe;
    f_step   = st + 32'd1;
    dwell    = dw + 16'd3;
    p_offset = ~po;
    cont     = ~cn;
  endtask

  // scoreboard: consumes exp_q on every step_stb and times the dwell gaps
  task automatic run_mon(input int dw, input int max_cyc);
    int last_stb;
    logic [63:0] e;
    last_stb = -1;
    n_stb = 0;
    n_done = 0;
    busy_cyc = 0;
    done_c = -1;
    for (int c = 0; c < max_cyc; c++) begin
      if (c > 0) tick();
      if (busy) busy_cyc++;
      if (step_stb) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 'x;
        check("f_ctrl_point", {32'd0, f_ctrl}, e);
        if (last_stb >= 0) check("dwell_gap", c - last_stb, dw + 1);
        last_stb = c;
        n_stb++;
      end
      if (done) begin
        n_done++;
        done_c = c;
        check("busy_at_done", busy, 0);
        break;
      end
    end
  endtask

  initial begin
    // reset
    repeat (2) tick();
    check("rst_f_ctrl", f_ctrl, 0);
    check("rst_p_ctrl", p_ctrl, 0);
    check("rst_busy", busy, 0);
    check("rst_step_stb", step_stb, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    // basic ramp 100..130 step 10, dwell 2
    exp_q = '{64'd100, 64'd110, 64'd120, 64'd130};
    drive_start(32'd100, 32'd130, 32'd10, 16'd2, 12'h5A5, 1'b0);
    check("t1_p_ctrl", p_ctrl, 12'h5A5);
    run_mon(2, 40);
    check("t1_n_stb", n_stb, 4);
    check("t1_n_done", n_done, 1);
    check("t1_busy_cyc", busy_cyc, 12);
    check("t1_done_cycle", done_c, 12);
    check("t1_exp_left", exp_q.size(), 0);
    tick();
    check("t1_idle_busy", busy, 0);
    check("t1_idle_done", done, 0);
    check("t1_hold_f", f_ctrl, 130);
    check("t1_hold_p", p_ctrl, 12'h5A5);

    // start while busy is ignored
    drive_start(32'd100, 32'd130, 32'd10, 16'd2, 12'h001, 1'b0);
    check("t2_first", f_ctrl, 100);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_q = '{64'd110, 64'd120, 64'd130};
    run_mon(2, 40);
    check("t2_n_stb", n_stb, 3);
    check("t2_busy_cyc", busy_cyc, 10);
    check("t2_n_done", n_done, 1);
    check("t2_done_cycle", done_c, 10);
    tick();

    // unaligned clamp to f_stop
    exp_q = '{64'd0, 64'd10, 64'd20, 64'd25};
    drive_start(32'd0, 32'd25, 32'd10, 16'd0, 12'h000, 1'b0);
    run_mon(0, 20);
    check("t3_n_stb", n_stb, 4);
    check("t3_busy_cyc", busy_cyc, 4);
    check("t3_n_done", n_done, 1);
    tick();

    // carry out of the word clamps instead of wrapping
    exp_q = '{64'hFFFF_FFF0, 64'hFFFF_FFFF};
    drive_start(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd0, 12'h0F0, 1'b0);
    run_mon(0, 20);
    check("t4_n_stb", n_stb, 2);
    check("t4_busy_cyc", busy_cyc, 2);
    check("t4_n_done", n_done, 1);
    tick();
    check("t4_hold_f", f_ctrl, 32'hFFFF_FFFF);

    // zero step: single point held dwell+1 cycles
    exp_q = '{64'd50};
    drive_start(32'd50, 32'd90, 32'd0, 16'd3, 12'h123, 1'b0);
    run_mon(3, 20);
    check("t5_n_stb", n_stb, 1);
    check("t5_busy_cyc", busy_cyc, 4);
    check("t5_n_done", n_done, 1);
    tick();

    // f_start above f_stop: single point
    exp_q = '{64'd200};
    drive_start(32'd200, 32'd100, 32'd5, 16'd1, 12'h321, 1'b0);
    run_mon(1, 20);
    check("t6_n_stb", n_stb, 1);
    check("t6_busy_cyc", busy_cyc, 2);
    check("t6_n_done", n_done, 1);
    tick();

    // continuous 3-point sweep, then abort mid-point
    exp_q = '{64'd100, 64'd110, 64'd120, 64'd100, 64'd110, 64'd120, 64'd100, 64'd110};
    drive_start(32'd100, 32'd120, 32'd10, 16'd1, 12'h007, 1'b1);
    run_mon(1, 15);
    check("t7_n_stb", n_stb, 8);
    check("t7_n_done", n_done, 0);
    check("t7_busy_cyc", busy_cyc, 15);
    check("t7_exp_left", exp_q.size(), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t7_abort_busy", busy, 0);
    check("t7_abort_stb", step_stb, 0);
    check("t7_abort_done", done, 0);
    check("t7_abort_hold", f_ctrl, 110);
    run_mon(1, 5);
    check("t7_post_stb", n_stb, 0);
    check("t7_post_done", n_done, 0);
    check("t7_post_busy", busy_cyc, 0);

    // start and abort together: no sweep
    f_start = 32'd500;
    f_stop = 32'd600;
    f_step = 32'd10;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("t8_busy", busy, 0);
    check("t8_stb", step_stb, 0);
    check("t8_hold", f_ctrl, 110);
    tick();
    check("t8_still_idle", busy, 0);

    // asynchronous reset mid-sweep
    drive_start(32'd100, 32'd130, 32'd10, 16'd2, 12'hABC, 1'b0);
    repeat (4) tick();
    check("t9_pre_f", f_ctrl, 110);
    rst_n = 1'b0;
    #1;
    check("t9_rst_f", f_ctrl, 0);
    check("t9_rst_p", p_ctrl, 0);
    check("t9_rst_busy", busy, 0);
    #1;
    rst_n = 1'b1;
    tick();
    check("t9_after_busy", busy, 0);

`ifdef DDS_SWEEP_TRI_EN
    // triangle sweep with continuous restart
    tri_mode = 1'b1;
    exp_q = '{64'd100, 64'd110, 64'd120, 64'd130, 64'd120,
              64'd110, 64'd100, 64'd110, 64'd120, 64'd130};
    drive_start(32'd100, 32'd130, 32'd10, 16'd0, 12'h000, 1'b1);
    tri_mode = 1'b0;
    run_mon(0, 10);
    check("t10_n_stb", n_stb, 10);
    check("t10_n_done", n_done, 0);
    check("t10_exp_left", exp_q.size(), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t10_abort_busy", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
